// File: rtl/nbus_arb2_pkg.sv
// Shared definitions for the native-bus two-requester arbiter.
package nbus_arb2_pkg;

  localparam int unsigned NBUS_ADDR_W = 32;
  localparam int unsigned NBUS_DATA_W = 32;
  localparam int unsigned NBUS_WEN_W  = 5;

  // Code 2'd3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic GNT_R0 = 1'b0;
  localparam logic GNT_R1 = 1'b1;

endpackage

// File: rtl/nbus_arb2_dfflr.sv
// Loadable register with synchronous active-low reset to a fixed value.
module dfflr #(
  parameter int unsigned W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         lden,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset wins over load; otherwise capture d when enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (lden) begin
      q <= d;
    end
  end

endmodule

// File: rtl/nbus_arb2.sv
// Round-robin arbiter merging two native-bus requesters onto one downstream port.
module nbus_arb2
  import nbus_arb2_pkg::*;
#(
  parameter int unsigned ADDR_W = NBUS_ADDR_W,
  parameter int unsigned DATA_W = NBUS_DATA_W,
  parameter int unsigned WEN_W  = NBUS_WEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              r0_val,
  output logic              r0_rdy,
  input  logic [ADDR_W-1:0] r0_adr,
  input  logic [WEN_W-1:0]  r0_wen,
  input  logic [DATA_W-1:0] r0_wdat,
  output logic [DATA_W-1:0] r0_rdat,
  input  logic              r1_val,
  output logic              r1_rdy,
  input  logic [ADDR_W-1:0] r1_adr,
  input  logic [WEN_W-1:0]  r1_wen,
  input  logic [DATA_W-1:0] r1_wdat,
  output logic [DATA_W-1:0] r1_rdat,
  output logic              d_val,
  input  logic              d_rdy,
  output logic [ADDR_W-1:0] d_adr,
  output logic [WEN_W-1:0]  d_wen,
  output logic [DATA_W-1:0] d_wdat,
  input  logic [DATA_W-1:0] d_rdat
);

  localparam int unsigned REQ_W = ADDR_W + WEN_W + DATA_W;

  state_e            state_d, state_q;
  logic [1:0]        state_raw_q;
  logic              gnt_d, gnt_q, gnt_ld;
  logic              last_d, last_q, last_ld;
  logic [REQ_W-1:0]  req_d, req_q;
  logic              req_ld;
  logic [DATA_W-1:0] resp_d, resp_q;
  logic              resp_ld;
  logic              win;

  // The FSM lives in a dfflr, so the enum is recovered by cast; code 3 hits the default arm.
  assign state_q = state_e'(state_raw_q);

  // Winner select, next-state and register load enables.
  always_comb begin
    state_d = state_q;
    gnt_ld  = 1'b0;
    last_ld = 1'b0;
    req_ld  = 1'b0;
    resp_ld = 1'b0;
    if (r0_val && r1_val) begin
      win = (last_q == GNT_R0) ? GNT_R1 : GNT_R0;
    end else if (r1_val) begin
      win = GNT_R1;
    end else begin
      win = GNT_R0;
    end
    gnt_d  = win;
    last_d = gnt_q;
    req_d  = (win == GNT_R1) ? {r1_adr, r1_wen, r1_wdat} : {r0_adr, r0_wen, r0_wdat};
    resp_d = d_rdat;
    case (state_q)
      IDLE: begin
        if (r0_val || r1_val) begin
          state_d = REQ;
          gnt_ld  = 1'b1;
          req_ld  = 1'b1;
        end
      end
      REQ: begin
        if (d_rdy) begin
          state_d = RESP;
          resp_ld = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        last_ld = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  dfflr #(.W(2), .RST_VAL(IDLE)) u_state (
    .clk(clk), .rst_n(rst_n), .lden(1'b1), .d(state_d), .q(state_raw_q)
  );

  dfflr #(.W(1), .RST_VAL(GNT_R0)) u_gnt (
    .clk(clk), .rst_n(rst_n), .lden(gnt_ld), .d(gnt_d), .q(gnt_q)
  );

  dfflr #(.W(1), .RST_VAL(GNT_R1)) u_last (
    .clk(clk), .rst_n(rst_n), .lden(last_ld), .d(last_d), .q(last_q)
  );

  dfflr #(.W(REQ_W), .RST_VAL('0)) u_req (
    .clk(clk), .rst_n(rst_n), .lden(req_ld), .d(req_d), .q(req_q)
  );

  dfflr #(.W(DATA_W), .RST_VAL('0)) u_resp (
    .clk(clk), .rst_n(rst_n), .lden(resp_ld), .d(resp_d), .q(resp_q)
  );

  // Outputs are pure decodes of flop state; no input reaches an output combinationally.
  assign d_val   = (state_q == REQ);
  assign d_adr   = req_q[REQ_W-1 -: ADDR_W];
  assign d_wen   = req_q[DATA_W +: WEN_W];
  assign d_wdat  = req_q[DATA_W-1:0];
  assign r0_rdy  = (state_q == RESP) && (gnt_q == GNT_R0);
  assign r1_rdy  = (state_q == RESP) && (gnt_q == GNT_R1);
  assign r0_rdat = resp_q;
  assign r1_rdat = resp_q;

endmodule
